// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants and types for the frame-RAM access arbiter.
// Port roles, RAM geometry and the read-return tag that rides the return pipeline.
package ram_arb_pkg;

    localparam int RAM_DEPTH  = 786432;
    localparam int RAM_ADDR_W = 24;

    localparam int PORT_SD   = 0;
    localparam int PORT_LIFE = 1;
    localparam int PORT_DISP = 2;

    localparam int PORT_W = 2;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic              oob;
    } ret_tag_t;

endpackage

// File: rtl/ram_access_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first eligible port scanning upward from last+1.
// Produces a one-hot grant plus its binary index; no state lives here.
module rr_priority_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = last;
        any = 1'b0;
        // Offset k=N wraps back onto last itself, so a lone requester can be re-granted.
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && elig[i] && (((int'(last) + k) % N) == i)) begin
                    gnt[i] = 1'b1;
                    idx    = IDX_W'(i);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing the single-port 1-bit frame RAM between the SD loader,
// the life-step engine and the display path; read data returns tagged per port.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DEPTH        = RAM_DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk_spi,
    input  logic                        reset_btn,
    input  logic                        load_lock,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS-1:0]        wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic                        rdata,
    output logic [ADDR_W-1:0]           ram_address,
    output logic                        ram_rden,
    output logic                        ram_wren,
    output logic                        ram_data,
    input  logic                        ram_q,
    output logic                        err_oob
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [NUM_PORTS-1:0] elig;
    logic [PORT_W-1:0]    pick_idx;
    logic                 pick_any;

    logic [ADDR_W-1:0] port_addr [NUM_PORTS];
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_wdata;
    logic              sel_oob;

    logic [PORT_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic              ram_rden_q, ram_rden_d;
    logic              ram_wren_q, ram_wren_d;
    logic              ram_data_q, ram_data_d;
    logic              err_oob_q, err_oob_d;
    ret_tag_t          ret_q [READ_LATENCY+1];
    ret_tag_t          ret_d [READ_LATENCY+1];

    // While a file loads only the SD port may compete.
    always_comb begin
        elig = req;
        if (load_lock) begin
            elig = req & NUM_PORTS'(1);
        end
    end

    rr_priority_pick #(
        .N     (NUM_PORTS),
        .IDX_W (PORT_W)
    ) u_pick (
        .elig (elig),
        .last (last_q),
        .gnt  (gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi] = addr[gi*ADDR_W +: ADDR_W];
            assign rvalid[gi]    = ret_q[READ_LATENCY].valid &&
                                   (ret_q[READ_LATENCY].port == PORT_W'(gi));
        end
    endgenerate

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                sel_addr  = port_addr[i];
                sel_we    = we[i];
                sel_wdata = wdata[i];
            end
        end
        sel_oob = ({1'b0, sel_addr} >= DEPTH_L);
    end

    always_comb begin
        last_d        = last_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_rden_d    = 1'b0;
        ram_wren_d    = 1'b0;
        err_oob_d     = err_oob_q;
        ret_d[0]      = '0;
        for (int s = 1; s <= READ_LATENCY; s++) begin
            ret_d[s] = ret_q[s-1];
        end
        if (pick_any) begin
            last_d        = pick_idx;
            ram_address_d = sel_addr;
            ram_data_d    = sel_wdata;
            ram_wren_d    = sel_we & ~sel_oob;
            ram_rden_d    = ~sel_we & ~sel_oob;
            err_oob_d     = err_oob_q | sel_oob;
            // Out-of-range reads still get a tag so the requester sees a (zero) return.
            if (!sel_we) begin
                ret_d[0] = '{valid: 1'b1, port: pick_idx, oob: sel_oob};
            end
        end
    end

    always_ff @(posedge clk_spi or posedge reset_btn) begin
        if (reset_btn) begin
            last_q        <= PORT_W'(NUM_PORTS-1);
            ram_address_q <= '0;
            ram_rden_q    <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_data_q    <= 1'b0;
            err_oob_q     <= 1'b0;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                ret_q[s] <= '0;
            end
        end else begin
            last_q        <= last_d;
            ram_address_q <= ram_address_d;
            ram_rden_q    <= ram_rden_d;
            ram_wren_q    <= ram_wren_d;
            ram_data_q    <= ram_data_d;
            err_oob_q     <= err_oob_d;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                ret_q[s] <= ret_d[s];
            end
        end
    end

    assign ram_address = ram_address_q;
    assign ram_rden    = ram_rden_q;
    assign ram_wren    = ram_wren_q;
    assign ram_data    = ram_data_q;
    assign err_oob     = err_oob_q;
    assign rdata       = ret_q[READ_LATENCY].valid & ~ret_q[READ_LATENCY].oob & ram_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port 1-bit frame RAM (786432 x 1, 1024x768 cells) among three requesters: SD-card loader (port 0), life-step engine (port 1) and display/readout path (port 2).
- Issues at most one RAM access per clk_spi cycle using round-robin arbitration.
- A lock input gives port 0 exclusive access while a file is loading.
- Returns read data to the originating port after the fixed RAM latency, tagged per port.

Parameters:
- NUM_PORTS, 3, number of requesters (2..4).
- ADDR_W, 24, address width of every port and of the RAM.
- DEPTH, 786432, valid address range is 0..DEPTH-1.
- READ_LATENCY, 1, cycles from the cycle ram_rden is high to the cycle ram_q is valid (1..4).

Ports:
- clk_spi  in  1  clock
- reset_btn  in  1  asynchronous reset, active-high
- load_lock  in  1  1 = only port 0 may be granted
- req  in  NUM_PORTS  per-port request, held until granted
- we  in  NUM_PORTS  per-port 1 = write, 0 = read
- addr  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS  per-port write bit
- gnt  out  NUM_PORTS  combinational one-hot accept; transfer occurs at the edge where req[i] & gnt[i]
- rvalid  out  NUM_PORTS  one-cycle read-return strobe per port
- rdata  out  1  read bit, valid when any rvalid is high
- ram_address  out  ADDR_W  registered RAM address
- ram_rden  out  1  registered read enable
- ram_wren  out  1  registered write enable
- ram_data  out  1  registered write data
- ram_q  in  1  RAM read data
- err_oob  out  1  sticky flag: an out-of-range access was accepted

Behaviour:
- Reset is decided: reset reset_btn, asynchronous, active-high; clock clk_spi. Everything in this block runs in that clock domain.
- Reset values:
  - ram_address = 0, ram_rden = 0, ram_wren = 0, ram_data = 0.
  - rvalid = 0, err_oob = 0.
  - Round-robin pointer last = NUM_PORTS-1, so port 0 has first priority.
  - Return pipeline cleared.
- Reset mid-operation: all in-flight reads are discarded; no rvalid is produced for them.
- Eligibility: elig = req, masked to bit 0 only when load_lock = 1.
- Grant: gnt is one-hot (or zero), chosen combinationally from elig, scanning upward from last+1 modulo NUM_PORTS. gnt depends only on req, load_lock and last; there is no path from gnt back into gnt.
- On the edge where gnt[i] & req[i] (cycle t):
  - last <= i.
  - ram_address <= addr_i, ram_data <= wdata_i.
  - ram_wren <= we_i & in-range; ram_rden <= ~we_i & in-range.
  - These strobes are high for exactly cycle t+1.
- With no grant, ram_rden = ram_wren = 0 on the next cycle; ram_address and ram_data hold their last values.
- Back-to-back accesses: one grant per cycle. The same port may be granted again next cycle only if no other port is eligible.
- Out-of-range (addr_i >= DEPTH):
  - The request is still granted; no RAM strobe is issued; err_oob sets and holds until reset.
  - A read still returns rvalid[i] with rdata = 0, so requesters never hang.
- Read return:
  - A tag {valid, port, oob} enters a READ_LATENCY+1 deep shift register at grant.
  - rvalid[port] pulses in cycle t+1+READ_LATENCY.
  - rdata = oob ? 0 : ram_q in that cycle, passed through combinationally from ram_q.
  - Writes produce no rvalid.
- load_lock changes:
  - Take effect on gnt in the same cycle (combinational).
  - Reads already accepted from ports 1/2 still complete and return.
- Write-then-read to the same address on consecutive grants returns the new value. The RAM is single-port and accesses are serialized, so no hazard exists.
- Requester contract: addr, we and wdata stay stable while req is high and ungranted. req may drop without a grant only when load_lock = 1 (abandoned request).

Decomposition:
- Package ram_arb_pkg holds:
  - RAM_DEPTH = 786432, RAM_ADDR_W = 24.
  - Port index constants PORT_SD = 0, PORT_LIFE = 1, PORT_DISP = 2.
  - Typedef of the return tag struct {valid, port[1:0], oob}.
- One sub-module, rr_priority_pick: combinational round-robin one-hot picker (elig, last -> gnt, idx).
- The return pipeline lives in the top of the block.

Test Plan:
- Reset, then port 0 writes 1 to addr 5; next cycle port 0 reads addr 5 -> gnt[0] in cycles t and t+1; ram_wren high in cycle t+1 with address 5, data 1; rvalid[0] in cycle t+3 with rdata = 1 (READ_LATENCY = 1).
- Ports 0, 1 and 2 request reads continuously -> grants rotate 0, 1, 2, 0, 1, 2; each rvalid arrives exactly 2 cycles after its grant, in grant order.
- load_lock = 1 with all three requesting -> only gnt[0] for 10 cycles. Drop load_lock -> the next grant goes to port 1 (last = 0).
- Port 2 reads addr 786432 -> granted; no ram_rden; rvalid[2] with rdata = 0; err_oob = 1, still 1 after 100 cycles.
- Assert reset_btn one cycle after a read grant -> all outputs 0 immediately; no rvalid after release; next grant goes to port 0.
- READ_LATENCY = 3 build with random mixed traffic against a reference memory model -> every read returns the last written value, and rvalid count equals granted read count.
